// File: rtl/oled_morse_pkg.sv
// rtl/oled_morse_pkg.sv - shared Morse code-word encoding constants and FSM states
package oled_morse_pkg;

    localparam int MOSE_W = 16;

    localparam logic [1:0] DOT_PAT  = 2'b01;
    localparam logic [1:0] DASH_PAT = 2'b11;

    // Reference letters as the OLED display decoder expects them.
    localparam logic [MOSE_W-1:0] LTR_E = 16'h0001;
    localparam logic [MOSE_W-1:0] LTR_T = 16'h0003;
    localparam logic [MOSE_W-1:0] LTR_I = 16'h0005;
    localparam logic [MOSE_W-1:0] LTR_A = 16'h000B;
    localparam logic [MOSE_W-1:0] LTR_Y = 16'h035B;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_EMIT
    } morse_state_t;

    // Bits consumed by one element: leading 0 separator (except first) plus the pattern.
    function automatic logic [1:0] elem_need(input logic [4:0] len, input logic dash);
        return (len == 5'd0 ? 2'd0 : 2'd1) + (dash ? 2'd2 : 2'd1);
    endfunction

endpackage

// File: rtl/morse_key_encoder_if.sv
// rtl/morse_key_encoder_if.sv - code-word output bundle towards the OLED text path
interface morse_key_encoder_if;
    import oled_morse_pkg::*;

    logic [MOSE_W-1:0] MOSE;
    logic              MOSE_VALID;
    logic              KEY_ERR;
    logic              BUSY;

    modport master (output MOSE, output MOSE_VALID, output KEY_ERR, output BUSY);
    modport slave  (input  MOSE, input  MOSE_VALID, input  KEY_ERR, input  BUSY);

endinterface

// File: rtl/morse_key_encoder_debounce.sv
// rtl/morse_key_encoder_debounce.sv - key synchronizer and ms-tick stability debouncer
module key_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY,
    input  logic tick,
    output logic ks,
    output logic kd
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);

    logic          k_meta;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            k_meta <= 1'b0;
            ks     <= 1'b0;
            kd     <= 1'b0;
            db_cnt <= '0;
        end else begin
            k_meta <= KEY;
            ks     <= k_meta;
            // Any return to the accepted level restarts the stability window.
            if (ks == kd) begin
                db_cnt <= '0;
            end else if (tick) begin
                if (db_cnt == DW'(DEBOUNCE_MS - 1)) begin
                    kd     <= ks;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/morse_key_encoder.sv
// rtl/morse_key_encoder.sv - telegraph key to packed 16-bit MOSE letter code
import oled_morse_pkg::*;

module morse_key_encoder #(
    parameter int CLKS_PER_MS = 100000,
    parameter int DEBOUNCE_MS = 20,
    parameter int DASH_MS     = 300,
    parameter int GAP_MS      = 600
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                KEY,
    morse_key_encoder_if.master mose_if
);

    localparam int PW = $clog2(CLKS_PER_MS + 1);

    logic [PW-1:0]     pre_cnt;
    logic              tick;
    logic              ks, kd, kd_q;
    logic              rise, fall;
    morse_state_t      state_q, state_d;
    logic [11:0]       ms;
    logic [MOSE_W-1:0] code, mose_q;
    logic [4:0]        len;
    logic              ovf, valid_q, err_q;
    logic              is_dash, fits;
    logic [1:0]        need, pat;

    assign tick = (pre_cnt == PW'(CLKS_PER_MS - 1));

    always_ff @(posedge CLK) begin
        if (RST || tick) pre_cnt <= '0;
        else             pre_cnt <= pre_cnt + 1'b1;
    end

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_debounce (
        .CLK  (CLK),
        .RST  (RST),
        .KEY  (KEY),
        .tick (tick),
        .ks   (ks),
        .kd   (kd)
    );

    assign rise    = kd & ~kd_q;
    assign fall    = ~kd & kd_q;
    assign is_dash = (ms >= 12'(DASH_MS));
    assign need    = elem_need(len, is_dash);
    assign pat     = is_dash ? DASH_PAT : DOT_PAT;
    assign fits    = !ovf && (({1'b0, len} + {4'b0, need}) <= 6'd16);

    always_comb begin
        state_d = state_q;
        case (state_q)
            // Sit out one debounce window so a key held through reset is seen before arming.
            ST_ARM:   if (!kd && !ks && ms >= 12'(DEBOUNCE_MS)) state_d = ST_IDLE;
            ST_IDLE:  if (rise) state_d = ST_PRESS;
            ST_PRESS: if (fall) state_d = ST_GAP;
            ST_GAP: begin
                if (rise)                      state_d = ST_PRESS;
                else if (ms >= 12'(GAP_MS))    state_d = ST_EMIT;
            end
            ST_EMIT:  state_d = ST_IDLE;
            default:  state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_ARM;
            kd_q    <= 1'b0;
            ms      <= '0;
            code    <= '0;
            len     <= '0;
            ovf     <= 1'b0;
            mose_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kd_q    <= kd;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (state_d != state_q)        ms <= '0;
            else if (tick && ms != 12'hFFF) ms <= ms + 1'b1;
            case (state_q)
                ST_ARM, ST_IDLE: begin
                    code <= '0;
                    len  <= '0;
                    ovf  <= 1'b0;
                end
                ST_PRESS: begin
                    if (fall) begin
                        if (fits) begin
                            code <= (code << need) | MOSE_W'(pat);
                            len  <= len + {3'b0, need};
                        end else begin
                            ovf  <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    valid_q <= 1'b1;
                    err_q   <= ovf;
                    mose_q  <= ovf ? '0 : code;
                end
                default: ;
            endcase
        end
    end

    assign mose_if.MOSE       = mose_q;
    assign mose_if.MOSE_VALID = valid_q;
    assign mose_if.KEY_ERR    = err_q;
    assign mose_if.BUSY       = (state_q == ST_PRESS) || (state_q == ST_GAP) || (state_q == ST_EMIT);

endmodule

// File: tb/tb_morse_key_encoder.sv
// tb/tb_morse_key_encoder.sv - self-checking bench for morse_key_encoder
module tb_morse_key_encoder;

    localparam int CPM  = 4;
    localparam int DEB  = 2;
    localparam int DASH = 10;
    localparam int GAP  = 20;

    logic CLK = 1'b0;
    logic RST;
    logic KEY;

    always #5 CLK = ~CLK;

    morse_key_encoder_if mif();

    morse_key_encoder #(
        .CLKS_PER_MS (CPM),
        .DEBOUNCE_MS (DEB),
        .DASH_MS     (DASH),
        .GAP_MS      (GAP)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .KEY     (KEY),
        .mose_if (mif)
    );

    typedef struct packed {
        logic [3:0]      n;
        logic [5:0][7:0] press;
        logic [7:0]      gap;
        logic [15:0]     mose;
        logic            err;
    } vec_t;

    typedef struct packed {
        logic [15:0] mose;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   valids = 0;
    int   pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ms(input int m);
        repeat (m * CPM) @(negedge CLK);
    endtask

    task automatic press_ms(input int p);
        KEY = 1'b1;
        wait_ms(p);
        KEY = 1'b0;
    endtask

    task automatic expect_letter(input logic [15:0] m, input logic er);
        sb.push_back({m, er});
        pushed++;
    endtask

    function automatic vec_t mk(input int n, input int p0, input int p1, input int p2,
                                input int p3, input int p4, input int p5, input int gap,
                                input logic [15:0] m, input logic er);
        vec_t v;
        v.n        = 4'(n);
        v.press[0] = 8'(p0);
        v.press[1] = 8'(p1);
        v.press[2] = 8'(p2);
        v.press[3] = 8'(p3);
        v.press[4] = 8'(p4);
        v.press[5] = 8'(p5);
        v.gap      = 8'(gap);
        v.mose     = m;
        v.err      = er;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        expect_letter(v.mose, v.err);
        for (int i = 0; i < int'(v.n); i++) begin
            press_ms(int'(v.press[i]));
            if (i < int'(v.n) - 1) wait_ms(int'(v.gap));
        end
        wait_ms(1);
        check($sformatf("busy_in_letter_%0d", idx), 32'(mif.BUSY), 32'd1);
        wait_ms(30);
        check($sformatf("letter_emitted_%0d", idx), 32'(sb.size()), 32'd0);
        check($sformatf("busy_idle_%0d", idx), 32'(mif.BUSY), 32'd0);
    endtask

    // Scoreboard: every MOSE_VALID must match the oldest pending letter.
    always @(negedge CLK) begin
        if (RST === 1'b0 && mif.MOSE_VALID === 1'b1) begin
            valids++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got MOSE=%04h with no letter pending", mif.MOSE);
            end else begin
                e = sb.pop_front();
                check("mose", 32'(mif.MOSE), 32'(e.mose));
                check("key_err", 32'(mif.KEY_ERR), 32'(e.err));
            end
        end
        if (mif.KEY_ERR === 1'b1 && mif.MOSE_VALID !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL key_err_without_valid: got KEY_ERR=1 MOSE_VALID=%0b expected 1", mif.MOSE_VALID);
        end
    end

    initial begin
        int lat;
        int snap;

        vecs[0] = mk(1,  4,  0,  0,  0,  0,  0,  5, 16'h0001, 1'b0);
        vecs[1] = mk(2,  4, 12,  0,  0,  0,  0,  5, 16'h000B, 1'b0);
        vecs[2] = mk(1, 12,  0,  0,  0,  0,  0,  5, 16'h0003, 1'b0);
        vecs[3] = mk(4, 12,  4, 12, 12,  0,  0,  5, 16'h035B, 1'b0);
        vecs[4] = mk(5, 12, 12, 12, 12, 12,  0,  5, 16'h36DB, 1'b0);
        vecs[5] = mk(6, 12, 12, 12, 12, 12, 12,  5, 16'h0000, 1'b1);
        vecs[6] = mk(2,  4,  4,  0,  0,  0,  0, 19, 16'h0005, 1'b0);
        vecs[7] = mk(1,  3,  0,  0,  0,  0,  0,  5, 16'h0001, 1'b0);

        RST = 1'b1;
        KEY = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_mose", 32'(mif.MOSE), 32'h0);
        check("reset_valid", 32'(mif.MOSE_VALID), 32'd0);
        check("reset_err", 32'(mif.KEY_ERR), 32'd0);
        check("reset_busy", 32'(mif.BUSY), 32'd0);
        RST = 1'b0;
        wait_ms(5);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Emit latency: 2 sync + debounce + gap after the raw release, tick-quantised.
        expect_letter(16'h0001, 1'b0);
        press_ms(4);
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge CLK);
            #1;
            if (mif.MOSE_VALID === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("emit_latency_window", 32'(lat >= 88 && lat <= 96), 32'd1);
        wait_ms(10);
        check("latency_letter_emitted", 32'(sb.size()), 32'd0);

        // Glitches while idle must not start a letter.
        @(negedge CLK) KEY = 1'b1;
        @(negedge CLK) KEY = 1'b0;
        wait_ms(3);
        KEY = 1'b1;
        wait_ms(1);
        KEY = 1'b0;
        wait_ms(1);
        check("busy_after_idle_glitch", 32'(mif.BUSY), 32'd0);
        wait_ms(30);

        // Drop-outs inside a long press keep it a single dash.
        expect_letter(16'h0003, 1'b0);
        KEY = 1'b1;
        wait_ms(5);
        KEY = 1'b0;
        @(negedge CLK) KEY = 1'b1;
        wait_ms(2);
        KEY = 1'b0;
        wait_ms(1);
        KEY = 1'b1;
        wait_ms(5);
        KEY = 1'b0;
        wait_ms(31);
        check("glitch_press_emitted", 32'(sb.size()), 32'd0);

        // Reset mid-letter with the key held down.
        press_ms(4);
        wait_ms(3);
        KEY = 1'b1;
        wait_ms(3);
        snap = valids;
        RST = 1'b1;
        @(negedge CLK) RST = 1'b0;
        check("midreset_mose", 32'(mif.MOSE), 32'h0);
        check("midreset_busy", 32'(mif.BUSY), 32'd0);
        check("midreset_valid", 32'(mif.MOSE_VALID), 32'd0);
        wait_ms(10);
        check("held_key_not_armed", 32'(mif.BUSY), 32'd0);
        KEY = 1'b0;
        wait_ms(30);
        check("no_valid_after_reset", 32'(valids), 32'(snap));
        expect_letter(16'h0001, 1'b0);
        press_ms(4);
        wait_ms(31);
        check("post_reset_letter_emitted", 32'(sb.size()), 32'd0);
        check("post_reset_busy", 32'(mif.BUSY), 32'd0);

        check("valid_total", 32'(valids), 32'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
